histogram_ctrl: RTL



---
 rtl/histogram_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/histogram_ctrl.sv
// Session sequencer for the data_statistics histogram block: clear, collect, drain, read out.
// Ports: clock/rst, cmd_start/dump_req, in_* sample stream, hs_* stats port, out_* result stream, status.
module histogram_ctrl #(
  parameter int DSIZE     = 8,
  parameter int DRAIN_CYC = 16,
  parameter int RD_LAT    = 2,
  parameter int FDEPTH    = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             in_rdy,
  output logic             hs_start,
  output logic             hs_finish,
  output logic [DSIZE-1:0] hs_data,
  output logic             hs_vld,
  output logic [DSIZE-1:0] hs_index,
  output logic             hs_get_summary,
  input  logic [31:0]      hs_summary,
  input  logic             dump_req,
  output logic [DSIZE-1:0] out_bin,
  output logic [31:0]      out_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic [31:0]      sample_cnt,
  output logic             done,
  output logic             busy
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int PW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW  = $clog2(FDEPTH + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_FLUSH,
    S_DRAIN,
    S_READY,
    S_DUMP
  } state_t;

  state_t state, state_n;

  logic             accept;
  logic [DCW-1:0]   drain_cnt;
  logic [DSIZE:0]   issue_cnt;
  logic             issue;
  logic [RD_LAT-1:0] tag_vld;
  logic [DSIZE-1:0] tag_bin [RD_LAT];
  logic [DSIZE-1:0] f_bin [FDEPTH];
  logic [31:0]      f_cnt [FDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_count, outstanding;
  logic             push, pop, head_last;
  logic [32:0]      sample_q;

  assign accept = (state == S_COLLECT) && in_vld;
  assign push   = tag_vld[RD_LAT-1];
  assign pop    = out_vld && out_rdy;

  // Tags in flight plus FIFO entries bound how many reads may be issued.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LAT; i++)
      outstanding = outstanding + CW'(tag_vld[i]);
  end

  assign issue = (state == S_DUMP) && !issue_cnt[DSIZE] &&
                 ((outstanding + fifo_count) < CW'(FDEPTH));

  assign head_last = (f_bin[rd_ptr] == '1);

  always_comb begin
    state_n        = state;
    in_rdy         = 1'b0;
    hs_start       = 1'b0;
    hs_finish      = 1'b0;
    hs_get_summary = 1'b0;
    busy           = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (cmd_start) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        hs_start = 1'b1;
        state_n  = S_COLLECT;
      end
      S_COLLECT: begin
        in_rdy = 1'b1;
        if (accept && in_last) state_n = S_FLUSH;
      end
      S_FLUSH: state_n = S_DRAIN;
      S_DRAIN: begin
        hs_finish = (drain_cnt == DCW'(DRAIN_CYC - 1));
        if (drain_cnt == '0) state_n = S_READY;
      end
      S_READY: begin
        busy = 1'b0;
        if (cmd_start)     state_n = S_CLEAR;
        else if (dump_req) state_n = S_DUMP;
      end
      S_DUMP: begin
        hs_get_summary = 1'b1;
        if (pop && head_last) state_n = S_READY;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= S_IDLE;
      drain_cnt  <= '0;
      issue_cnt  <= '0;
      tag_vld    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hs_vld     <= 1'b0;
      hs_data    <= '0;
      sample_q   <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == S_DRAIN) && (drain_cnt == '0);

      if (state == S_FLUSH)
        drain_cnt <= DCW'(DRAIN_CYC - 1);
      else if ((state == S_DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - 1'b1;

      hs_vld <= accept;
      if (accept) hs_data <= in_data;

      // Cleared on entry so the count reads 0 during CLEAR itself.
      if (state_n == S_CLEAR)
        sample_q <= '0;
      else if (accept && !sample_q[32])
        sample_q <= sample_q + 1'b1;

      if (state != S_DUMP)
        issue_cnt <= '0;
      else if (issue)
        issue_cnt <= issue_cnt + 1'b1;

      tag_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++)
        tag_vld[i] <= tag_vld[i-1];

      if (push)
        wr_ptr <= (wr_ptr == PW'(FDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    tag_bin[0] <= issue_cnt[DSIZE-1:0];
    for (int i = 1; i < RD_LAT; i++)
      tag_bin[i] <= tag_bin[i-1];
    if (push) begin
      f_bin[wr_ptr] <= tag_bin[RD_LAT-1];
      f_cnt[wr_ptr] <= hs_summary;
    end
  end

  // Low bits of the issue counter wrap to 0 once the sweep ends.
  assign hs_index   = issue_cnt[DSIZE-1:0];
  assign out_vld    = (fifo_count != '0);
  assign out_bin    = out_vld ? f_bin[rd_ptr] : '0;
  assign out_cnt    = out_vld ? f_cnt[rd_ptr] : '0;
  assign out_last   = out_vld && head_last;
  assign sample_cnt = sample_q[32] ? 32'hFFFF_FFFF : sample_q[31:0];

endmodule
